// File: rtl/tank_cmd_decoder_if.sv
// tank_cmd_decoder_if: keycode in, debounced movement and fire controls out.
//   master : the keycode source / downstream consumer side (drives keycode)
//   slave  : the decoder side (drives move_code, move_valid, fire_pulse,
//            fire_busy, frame_tick)
interface tank_cmd_decoder_if;
  localparam int unsigned KEY_W = 16;

  logic [KEY_W-1:0] keycode;     // two key slots: [7:0] slot 0, [15:8] slot 1
  logic [KEY_W-1:0] move_code;   // debounced canonical movement keycode
  logic             move_valid;  // move_code is nonzero
  logic             fire_pulse;  // one-cycle shot request
  logic             fire_busy;   // fire logic not ready for a new shot
  logic             frame_tick;  // one-cycle strobe per frame_clk rising edge

  modport master (
    output keycode,
    input  move_code,
    input  move_valid,
    input  fire_pulse,
    input  fire_busy,
    input  frame_tick
  );

  modport slave (
    input  keycode,
    output move_code,
    output move_valid,
    output fire_pulse,
    output fire_busy,
    output frame_tick
  );
endinterface

// File: rtl/tank_cmd_decoder.sv
// tank_cmd_decoder: per-frame keycode conditioner for the tank motion block.
// Samples the USB keycode once per video frame, debounces W/A/S/D into one
// canonical movement code and turns the space key into a rate-limited
// single-cycle fire strobe.
//
// Ports:
//   Clk        system clock, all state on its rising edge
//   Reset      synchronous, active-high reset
//   frame_clk  vsync-rate frame signal, treated as asynchronous data
//   bus        tank_cmd_decoder_if.slave (keycode in; move_code, move_valid,
//              fire_pulse, fire_busy, frame_tick out, all registered)
//
// Parameters:
//   STABLE_FRAMES    frames a decoded move must persist (1..15)
//   COOLDOWN_FRAMES  frames of fire inhibit after a shot (0..255)
//
// Build option: define AUTOFIRE_EN to let a held space key refire every
// COOLDOWN_FRAMES+1 frames; otherwise space must be released between shots.
module tank_cmd_decoder #(
  parameter int unsigned STABLE_FRAMES   = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  tank_cmd_decoder_if.slave    bus
);

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned SLOT_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STB_W  = 4;

  localparam logic [STB_W-1:0] STABLE_THR    = STB_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] COOLDOWN_INIT = CNT_W'(COOLDOWN_FRAMES);

  localparam logic [SLOT_W-1:0] KEY_W_UP    = 8'h1A;
  localparam logic [SLOT_W-1:0] KEY_A_LEFT  = 8'h04;
  localparam logic [SLOT_W-1:0] KEY_S_DOWN  = 8'h16;
  localparam logic [SLOT_W-1:0] KEY_D_RIGHT = 8'h07;
  localparam logic [SLOT_W-1:0] KEY_SPACE   = 8'h2C;

  typedef enum logic [1:0] {
    READY        = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } fire_state_t;

  // State entered when the cooldown runs out (or immediately for a zero cooldown)
`ifdef AUTOFIRE_EN
  localparam fire_state_t EXPIRE_STATE = READY;
`else
  localparam fire_state_t EXPIRE_STATE = WAIT_RELEASE;
`endif
  localparam logic EXPIRE_BUSY = (EXPIRE_STATE != READY);

  // Frame edge detect; all three flops reset high so only a real 0->1 ticks
  logic sync1_q, sync2_q, hist_q, tick_q;

  logic [KEY_W-1:0] cand_q, move_q;
  logic [STB_W-1:0] stable_cnt_q;
  logic             move_valid_q;

  fire_state_t      fire_state_q;
  logic [CNT_W-1:0] cooldown_q;
  logic             fire_pulse_q, fire_busy_q;

  logic [SLOT_W-1:0] slot0_c, slot1_c;
  logic [KEY_W-1:0]  decoded_c, cand_nxt_c;
  logic [STB_W-1:0]  stable_cnt_nxt_c;
  logic              fire_det_c;

  function automatic logic is_move_key(input logic [SLOT_W-1:0] k);
    return (k == KEY_W_UP) || (k == KEY_A_LEFT) ||
           (k == KEY_S_DOWN) || (k == KEY_D_RIGHT);
  endfunction

  // Keycode decode and debounce next-state; only consumed on tick cycles
  always_comb begin
    slot0_c          = bus.keycode[SLOT_W-1:0];
    slot1_c          = bus.keycode[KEY_W-1:SLOT_W];
    decoded_c        = '0;
    cand_nxt_c       = cand_q;
    stable_cnt_nxt_c = stable_cnt_q;

    // Slot 0 has priority over slot 1
    if (is_move_key(slot0_c)) begin
      decoded_c = KEY_W'(slot0_c);
    end else if (is_move_key(slot1_c)) begin
      decoded_c = KEY_W'(slot1_c);
    end

    fire_det_c = (slot0_c == KEY_SPACE) || (slot1_c == KEY_SPACE);

    if (decoded_c == cand_q) begin
      if (stable_cnt_q != '1) begin
        stable_cnt_nxt_c = stable_cnt_q + STB_W'(1);
      end
    end else begin
      cand_nxt_c       = decoded_c;
      stable_cnt_nxt_c = STB_W'(1);
    end
  end

  // Frame sync, debounce and fire FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      hist_q       <= 1'b1;
      tick_q       <= 1'b0;
      cand_q       <= '0;
      stable_cnt_q <= '0;
      move_q       <= '0;
      move_valid_q <= 1'b0;
      fire_state_q <= READY;
      cooldown_q   <= '0;
      fire_pulse_q <= 1'b0;
      fire_busy_q  <= 1'b0;
    end else begin
      sync1_q      <= frame_clk;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      tick_q       <= sync2_q & ~hist_q;
      fire_pulse_q <= 1'b0;

      // Keycode is consumed only on the edge that closes the tick cycle
      if (tick_q) begin
        cand_q       <= cand_nxt_c;
        stable_cnt_q <= stable_cnt_nxt_c;
        if (stable_cnt_nxt_c >= STABLE_THR) begin
          move_q       <= cand_nxt_c;
          move_valid_q <= (cand_nxt_c != '0);
        end

        unique case (fire_state_q)
          READY: begin
            if (fire_det_c) begin
              fire_pulse_q <= 1'b1;
              cooldown_q   <= COOLDOWN_INIT;
              if (COOLDOWN_INIT == '0) begin
                fire_state_q <= EXPIRE_STATE;
                fire_busy_q  <= EXPIRE_BUSY;
              end else begin
                fire_state_q <= COOLDOWN;
                fire_busy_q  <= 1'b1;
              end
            end
          end
          COOLDOWN: begin
            // Counter only lives here with a value >= 1; guard keeps it off 0-1
            if (cooldown_q <= CNT_W'(1)) begin
              cooldown_q   <= '0;
              fire_state_q <= EXPIRE_STATE;
              fire_busy_q  <= EXPIRE_BUSY;
            end else begin
              cooldown_q <= cooldown_q - CNT_W'(1);
            end
          end
          WAIT_RELEASE: begin
            if (!fire_det_c) begin
              fire_state_q <= READY;
              fire_busy_q  <= 1'b0;
            end
          end
          default: begin
            fire_state_q <= READY;
            fire_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.frame_tick = tick_q;
  assign bus.move_code  = move_q;
  assign bus.move_valid = move_valid_q;
  assign bus.fire_pulse = fire_pulse_q;
  assign bus.fire_busy  = fire_busy_q;

endmodule

// File: tb/tb_tank_cmd_decoder.sv
// tb_tank_cmd_decoder: self-checking bench for tank_cmd_decoder with a
// frame-level reference model (run-length debounce, shot-history fire rules).
module tb_tank_cmd_decoder;

`ifdef AUTOFIRE_EN
  localparam int CD   = 3;
  localparam bit AUTO = 1'b1;
`else
  localparam int CD   = 30;
  localparam bit AUTO = 1'b0;
`endif
  localparam int STB = 2;

  logic Clk       = 1'b0;
  logic Reset     = 1'b1;
  logic frame_clk = 1'b1;

  tank_cmd_decoder_if bus ();

  tank_cmd_decoder #(
    .STABLE_FRAMES  (STB),
    .COOLDOWN_FRAMES(CD)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .bus      (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ticks = 0;
  int n_pulses = 0;

  // Reference model state
  bit          started = 1'b0;
  bit          p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;  // frame_clk samples k-1, k-2, k-3
  bit          e_tick = 1'b0, e_valid = 1'b0, e_pulse = 1'b0, e_busy = 1'b0;
  logic [15:0] e_move = '0;
  logic [15:0] last_dec = '0;
  int          run = 0;
  int          t_idx = 0, last_shot = 0;
  bit          shot_ever = 1'b0, released = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_decode(input logic [15:0] kc);
    logic [7:0] s0, s1;
    s0 = kc[7:0];
    s1 = kc[15:8];
    if (s0 inside {8'h1A, 8'h04, 8'h16, 8'h07}) return {8'h00, s0};
    if (s1 inside {8'h1A, 8'h04, 8'h16, 8'h07}) return {8'h00, s1};
    return 16'h0000;
  endfunction

  // One frame of spec behaviour, applied to the snapshot keycode
  task automatic model_frame(input logic [15:0] kc);
    logic [15:0] d;
    bit sp, ready;
    d = ref_decode(kc);
    if (d == last_dec) run = (run < 100) ? run + 1 : run;
    else run = 1;
    last_dec = d;
    if (run >= STB) e_move = d;
    e_valid = (e_move != 16'h0000);

    sp = (kc[7:0] == 8'h2C) || (kc[15:8] == 8'h2C);
    t_idx++;
    ready = !shot_ever || (AUTO ? (t_idx >= last_shot + CD + 1) : released);
    if (sp && ready) begin
      e_pulse   = 1'b1;
      shot_ever = 1'b1;
      last_shot = t_idx;
      released  = 1'b0;
    end else if (!sp && shot_ever && (t_idx >= last_shot + CD + 1)) begin
      released = 1'b1;
    end
    e_busy = shot_ever && (AUTO ? (t_idx < last_shot + CD) : !released);
  endtask

  // Model advances on every active edge using the inputs driven before it
  always @(posedge Clk) begin
    started = 1'b1;
    if (Reset) begin
      p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
      e_tick = 1'b0; e_move = '0; e_valid = 1'b0; e_pulse = 1'b0; e_busy = 1'b0;
      run = 0; last_dec = '0; t_idx = 0; last_shot = 0;
      shot_ever = 1'b0; released = 1'b0;
    end else begin
      e_pulse = 1'b0;
      if (e_tick) model_frame(bus.keycode);
      // Tick after edge k needs frame_clk sampled high at k-2 and low at k-3
      e_tick = p2 & ~p3;
      p3 = p2; p2 = p1; p1 = frame_clk;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge Clk) begin
    if (started) begin
      check("frame_tick", 16'(bus.frame_tick), 16'(e_tick));
      check("move_code",  bus.move_code,       e_move);
      check("move_valid", 16'(bus.move_valid), 16'(e_valid));
      check("fire_pulse", 16'(bus.fire_pulse), 16'(e_pulse));
      check("fire_busy",  16'(bus.fire_busy),  16'(e_busy));
      if (bus.frame_tick) n_ticks++;
      if (bus.fire_pulse) n_pulses++;
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // One frame: low phase (optionally with junk keycode), then high phase.
  // The snapshot edge is the 4th edge of the high phase; returns just after it.
  task automatic frame(input logic [15:0] kc, input bit garbage, input bit rst_at_sample);
    bus.keycode = garbage ? 16'($urandom) : kc;
    frame_clk   = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    bus.keycode = kc;
    frame_clk   = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    if (rst_at_sample) Reset = 1'b1;
    @(negedge Clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int p0, t0;
    logic [11:0] mask;
    logic [7:0] pool [8];
    logic [15:0] kc;

    bus.keycode = '0;
    // Reset with frame_clk high, then stay high: no tick, all outputs 0
    repeat (3) @(negedge Clk);
    #1;
    Reset = 1'b0;
    t0 = n_ticks;
    repeat (5) @(negedge Clk);
    #1;
    check("no_tick_after_reset", 16'(n_ticks - t0), 16'd0);
    check("rst_move_code", bus.move_code, 16'h0000);
    check("rst_busy", 16'(bus.fire_busy), 16'd0);

    // W held: 0 after first tick, 1A after second
    frame(16'h001A, 1'b0, 1'b0);
    check("w_tick1_move", bus.move_code, 16'h0000);
    check("w_tick1_valid", 16'(bus.move_valid), 16'd0);
    frame(16'h001A, 1'b0, 1'b0);
    check("w_tick2_move", bus.move_code, 16'h001A);
    check("w_tick2_valid", 16'(bus.move_valid), 16'd1);

    // Alternating A/D never settles; junk between ticks must be ignored
    do_reset();
    for (int i = 0; i < 6; i++) begin
      frame((i % 2) ? 16'h0007 : 16'h0004, 1'b1, 1'b0);
      check("alt_move", bus.move_code, 16'h0000);
    end

    // Slot priority and movement+fire on one snapshot
    frame(16'h0716, 1'b0, 1'b0);
    frame(16'h0716, 1'b0, 1'b0);
    check("slot0_wins", bus.move_code, 16'h0016);
    p0 = n_pulses;
    frame(16'h1A2C, 1'b0, 1'b0);
    check("combo_pulse", 16'(bus.fire_pulse), 16'd1);
    frame(16'h1A2C, 1'b0, 1'b0);
    check("combo_move", bus.move_code, 16'h001A);
    check("combo_one_pulse", 16'(n_pulses - p0), 16'd1);
    check("combo_busy", 16'(bus.fire_busy), 16'd1);

`ifndef AUTOFIRE_EN
    // Space held 40 frames: one shot, then stuck waiting for release
    do_reset();
    p0 = n_pulses;
    for (int i = 0; i < 40; i++) frame(16'h002C, 1'b0, 1'b0);
    check("hold_pulses", 16'(n_pulses - p0), 16'd1);
    check("hold_busy", 16'(bus.fire_busy), 16'd1);
    frame(16'h0000, 1'b0, 1'b0);
    check("release_busy", 16'(bus.fire_busy), 16'd0);
    frame(16'h002C, 1'b0, 1'b0);
    check("repress_pulse", 16'(bus.fire_pulse), 16'd1);
    check("repress_count", 16'(n_pulses - p0), 16'd2);
`else
    // Autofire: held space fires on frames 1, 5 and 9
    do_reset();
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      p0 = n_pulses;
      frame(16'h002C, 1'b0, 1'b0);
      if (n_pulses != p0) mask[i] = 1'b1;
    end
    check("autofire_frames", 16'(mask), 16'h0111);
    do_reset();
    for (int i = 0; i < 4; i++) frame(16'h002C, 1'b0, 1'b0);
    frame(16'h002C, 1'b0, 1'b1);
    check("auto_rst_pulse", 16'(bus.fire_pulse), 16'd0);
    check("auto_rst_busy", 16'(bus.fire_busy), 16'd0);
    Reset = 1'b0;
`endif

    // Reset on the snapshot edge drops the pending shot
    do_reset();
    frame(16'h002C, 1'b0, 1'b1);
    check("rst_drop_pulse", 16'(bus.fire_pulse), 16'd0);
    check("rst_drop_busy", 16'(bus.fire_busy), 16'd0);
    Reset = 1'b0;
    frame(16'h002C, 1'b0, 1'b0);
    check("after_rst_pulse", 16'(bus.fire_pulse), 16'd1);

    // Randomised frames, checked every cycle against the model
    do_reset();
    pool = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h2C, 8'h55};
    kc = '0;
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        kc = {pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]};
        if ($urandom_range(0, 7) == 0) kc[7:0] = 8'($urandom);
      end
      frame(kc, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
